// File: rtl/mtr_pwm_decode_if.sv
// Signal bundle between the H-bridge PWM pins and the PWM decode monitor.
// The master side drives enable and the four PWM lines; the slave side (the
// decoder) returns the measured speeds, directions, shoot flags and strobe.
interface mtr_pwm_decode_if #(
    parameter int WIN_W = 11
);
    logic             en;
    logic             PWM_frwrd_lft;
    logic             PWM_rev_lft;
    logic             PWM_frwrd_rght;
    logic             PWM_rev_rght;
    logic [WIN_W-1:0] lft_spd_meas;
    logic             lft_rev_meas;
    logic [WIN_W-1:0] rght_spd_meas;
    logic             rght_rev_meas;
    logic             lft_shoot;
    logic             rght_shoot;
    logic             meas_vld;

    modport master (
        output en,
        output PWM_frwrd_lft,
        output PWM_rev_lft,
        output PWM_frwrd_rght,
        output PWM_rev_rght,
        input  lft_spd_meas,
        input  lft_rev_meas,
        input  rght_spd_meas,
        input  rght_rev_meas,
        input  lft_shoot,
        input  rght_shoot,
        input  meas_vld
    );

    modport slave (
        input  en,
        input  PWM_frwrd_lft,
        input  PWM_rev_lft,
        input  PWM_frwrd_rght,
        input  PWM_rev_rght,
        output lft_spd_meas,
        output lft_rev_meas,
        output rght_spd_meas,
        output rght_rev_meas,
        output lft_shoot,
        output rght_shoot,
        output meas_vld
    );
endinterface

// File: rtl/mtr_pwm_decode.sv
// PWM decode monitor: turns the left/right forward/reverse PWM pairs back into
// a signed speed (magnitude + reverse flag) measured over fixed windows of
// 2**WIN_W clocks, and flags shoot-through (forward and reverse both high).
// Windows are free-running from enable, so no phase lock to the driver is needed.
module mtr_pwm_decode #(
    parameter int WIN_W = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    mtr_pwm_decode_if.slave bus
);

    // Per-direction counters need one extra bit: a full window of one
    // direction counts 2**WIN_W, which is one past the largest speed code.
    localparam int CNT_W = WIN_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic             r_en;
    logic             r_frwrdLft;
    logic             r_revLft;
    logic             r_frwrdRght;
    logic             r_revRght;

    logic [WIN_W-1:0] r_winCnt;
    logic [CNT_W-1:0] r_fCntLft;
    logic [CNT_W-1:0] r_rCntLft;
    logic [CNT_W-1:0] r_fCntRght;
    logic [CNT_W-1:0] r_rCntRght;
    logic             r_stickyLft;
    logic             r_stickyRght;

    logic [WIN_W-1:0] r_lftSpd;
    logic             r_lftRev;
    logic [WIN_W-1:0] r_rghtSpd;
    logic             r_rghtRev;
    logic             r_lftShoot;
    logic             r_rghtShoot;
    logic             r_measVld;

    logic             w_measEdge;
    logic             w_winEnd;

    logic             w_fIncLft;
    logic             w_rIncLft;
    logic             w_bothLft;
    logic             w_fIncRght;
    logic             w_rIncRght;
    logic             w_bothRght;

    logic [CNT_W-1:0] w_fTotLft;
    logic [CNT_W-1:0] w_rTotLft;
    logic [CNT_W-1:0] w_fTotRght;
    logic [CNT_W-1:0] w_rTotRght;
    logic [CNT_W-1:0] w_diffLft;
    logic [CNT_W-1:0] w_diffRght;
    logic             w_revLft;
    logic             w_revRght;
    logic [WIN_W-1:0] w_spdLft;
    logic [WIN_W-1:0] w_spdRght;

    assign bus.lft_spd_meas  = r_lftSpd;
    assign bus.lft_rev_meas  = r_lftRev;
    assign bus.rght_spd_meas = r_rghtSpd;
    assign bus.rght_rev_meas = r_rghtRev;
    assign bus.lft_shoot     = r_lftShoot;
    assign bus.rght_shoot    = r_rghtShoot;
    assign bus.meas_vld      = r_measVld;

    // Sample stage: enable is registered together with the PWM pins so the
    // first sample of a window is the one taken on the edge after enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en        <= 1'b0;
            r_frwrdLft  <= 1'b0;
            r_revLft    <= 1'b0;
            r_frwrdRght <= 1'b0;
            r_revRght   <= 1'b0;
        end else begin
            r_en        <= bus.en;
            r_frwrdLft  <= bus.PWM_frwrd_lft;
            r_revLft    <= bus.PWM_rev_lft;
            r_frwrdRght <= bus.PWM_frwrd_rght;
            r_revRght   <= bus.PWM_rev_rght;
        end
    end

    // State register for the IDLE/MEAS controller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state plus the per-edge measure/window-end qualifiers; an edge that
    // sees enable low in MEAS leaves measurement and does not count.
    always_comb begin
        w_nextState = r_state;
        w_measEdge  = 1'b0;
        w_winEnd    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_en) begin
                    w_nextState = MEAS;
                end
            end
            MEAS: begin
                if (!r_en) begin
                    w_nextState = IDLE;
                end else begin
                    w_measEdge = 1'b1;
                    w_winEnd   = (r_winCnt == '1);
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Classify the current samples: a clean forward or reverse cycle counts
    // in its own counter, while both-high counts nowhere and marks shoot-through.
    always_comb begin
        w_fIncLft  = r_frwrdLft & ~r_revLft;
        w_rIncLft  = r_revLft & ~r_frwrdLft;
        w_bothLft  = r_frwrdLft & r_revLft;
        w_fIncRght = r_frwrdRght & ~r_revRght;
        w_rIncRght = r_revRght & ~r_frwrdRght;
        w_bothRght = r_frwrdRght & r_revRght;
    end

    // Window totals including this edge's sample, the net direction, and the
    // magnitude clamped to the largest speed code.
    always_comb begin
        w_fTotLft  = r_fCntLft + CNT_W'(w_fIncLft);
        w_rTotLft  = r_rCntLft + CNT_W'(w_rIncLft);
        w_fTotRght = r_fCntRght + CNT_W'(w_fIncRght);
        w_rTotRght = r_rCntRght + CNT_W'(w_rIncRght);

        w_revLft   = (w_rTotLft > w_fTotLft);
        w_revRght  = (w_rTotRght > w_fTotRght);

        w_diffLft  = w_revLft ? (w_rTotLft - w_fTotLft) : (w_fTotLft - w_rTotLft);
        w_diffRght = w_revRght ? (w_rTotRght - w_fTotRght) : (w_fTotRght - w_rTotRght);

        w_spdLft   = w_diffLft[WIN_W] ? '1 : w_diffLft[WIN_W-1:0];
        w_spdRght  = w_diffRght[WIN_W] ? '1 : w_diffRght[WIN_W-1:0];
    end

    // Window counter and accumulators: run only on measuring edges, restart
    // at each window end, and sit at zero whenever not measuring so a dropped
    // enable discards the partial window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_winCnt     <= '0;
            r_fCntLft    <= '0;
            r_rCntLft    <= '0;
            r_fCntRght   <= '0;
            r_rCntRght   <= '0;
            r_stickyLft  <= 1'b0;
            r_stickyRght <= 1'b0;
        end else if (!w_measEdge || w_winEnd) begin
            r_winCnt     <= '0;
            r_fCntLft    <= '0;
            r_rCntLft    <= '0;
            r_fCntRght   <= '0;
            r_rCntRght   <= '0;
            r_stickyLft  <= 1'b0;
            r_stickyRght <= 1'b0;
        end else begin
            r_winCnt     <= r_winCnt + WIN_W'(1);
            r_fCntLft    <= w_fTotLft;
            r_rCntLft    <= w_rTotLft;
            r_fCntRght   <= w_fTotRght;
            r_rCntRght   <= w_rTotRght;
            r_stickyLft  <= r_stickyLft | w_bothLft;
            r_stickyRght <= r_stickyRght | w_bothRght;
        end
    end

    // Result registers: load only at a window end and hold otherwise; the
    // strobe is high for exactly the cycle after each window end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lftSpd    <= '0;
            r_lftRev    <= 1'b0;
            r_rghtSpd   <= '0;
            r_rghtRev   <= 1'b0;
            r_lftShoot  <= 1'b0;
            r_rghtShoot <= 1'b0;
            r_measVld   <= 1'b0;
        end else begin
            r_measVld <= w_winEnd;
            if (w_winEnd) begin
                r_lftSpd    <= w_spdLft;
                r_lftRev    <= w_revLft;
                r_rghtSpd   <= w_spdRght;
                r_rghtRev   <= w_revRght;
                r_lftShoot  <= r_stickyLft | w_bothLft;
                r_rghtShoot <= r_stickyRght | w_bothRght;
            end
        end
    end

endmodule

// File: tb/tb_mtr_pwm_decode.sv
// Bench for the PWM decode monitor. Each window's PWM pattern is generated from
// counts of both-high, forward-only and reverse-only cycles per side; the
// expected result is computed from those counts and queued, then popped and
// compared when meas_vld strobes.
module tb_mtr_pwm_decode;

    localparam int WIN_W = 11;
    localparam int WIN   = 1 << WIN_W;

    typedef struct packed {
        logic [WIN_W-1:0] spdL;
        logic             revL;
        logic [WIN_W-1:0] spdR;
        logic             revR;
        logic             shootL;
        logic             shootR;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;

    res_t sbQ[$];
    int   errors = 0;
    int   checks = 0;

    mtr_pwm_decode_if #(.WIN_W(WIN_W)) bus ();

    mtr_pwm_decode #(.WIN_W(WIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 50MHz system clock.
    always #10 clk = ~clk;

    // Snapshot of all measurement outputs in scoreboard form.
    function automatic res_t observed();
        res_t r;
        r.spdL   = bus.lft_spd_meas;
        r.revL   = bus.lft_rev_meas;
        r.spdR   = bus.rght_spd_meas;
        r.revR   = bus.rght_rev_meas;
        r.shootL = bus.lft_shoot;
        r.shootR = bus.rght_shoot;
        return r;
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("spdL=%0d revL=%0b spdR=%0d revR=%0b shootL=%0b shootR=%0b",
                         r.spdL, r.revL, r.spdR, r.revR, r.shootL, r.shootR);
    endfunction

    // Clamped magnitude of clean forward minus clean reverse counts.
    function automatic logic [WIN_W-1:0] magOf(input int f, input int r);
        int d;
        d = (f > r) ? (f - r) : (r - f);
        if (d > WIN - 1) d = WIN - 1;
        return WIN_W'(d);
    endfunction

    function automatic res_t model(input int bL, input int fL, input int rL,
                                   input int bR, input int fR, input int rR);
        res_t r;
        r.spdL   = magOf(fL, rL);
        r.revL   = (rL > fL);
        r.spdR   = magOf(fR, rR);
        r.revR   = (rR > fR);
        r.shootL = (bL > 0);
        r.shootR = (bR > 0);
        return r;
    endfunction

    // Drive one full window: per side, b cycles both high, then f forward-only,
    // then r reverse-only, remainder low. The expected result is queued first.
    task automatic applyStimulus(input int bL, input int fL, input int rL,
                                 input int bR, input int fR, input int rR);
        sbQ.push_back(model(bL, fL, rL, bR, fR, rR));
        for (int i = 0; i < WIN; i++) begin
            @(negedge clk);
            bus.PWM_frwrd_lft  = (i < bL + fL);
            bus.PWM_rev_lft    = (i < bL) || ((i >= bL + fL) && (i < bL + fL + rL));
            bus.PWM_frwrd_rght = (i < bR + fR);
            bus.PWM_rev_rght   = (i < bR) || ((i >= bR + fR) && (i < bR + fR + rR));
        end
    endtask

    // Bounded wait for the next strobe; reports the posedges it took.
    task automatic waitVld(input int budget, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.meas_vld === 1'b1) seen = 1'b1;
        end
    endtask

    // Raise enable and return just after the edge that samples it.
    task automatic startMeas();
        @(negedge clk);
        bus.en = 1'b1;
        @(posedge clk);
    endtask

    task automatic stopMeas();
        @(negedge clk);
        bus.en             = 1'b0;
        bus.PWM_frwrd_lft  = 1'b0;
        bus.PWM_rev_lft    = 1'b0;
        bus.PWM_frwrd_rght = 1'b0;
        bus.PWM_rev_rght   = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n              = 1'b0;
        bus.en             = 1'b0;
        bus.PWM_frwrd_lft  = 1'b0;
        bus.PWM_rev_lft    = 1'b0;
        bus.PWM_frwrd_rght = 1'b0;
        bus.PWM_rev_rght   = 1'b0;
        #45;
        checks++;
        if (observed() !== '0)
            begin errors++; $display("[TB] FAIL reset_outputs: got %s, expected all 0", fmt(observed())); end
        checks++;
        if (bus.meas_vld !== 1'b0)
            begin errors++; $display("[TB] FAIL reset_vld: got %b, expected 0", bus.meas_vld); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Left forward 15/2048 over two windows: values plus first latency and period.
    task automatic test_single_frwrd();
        int cyc; bit seen; res_t exp;
        startMeas();
        fork
            begin
                applyStimulus(0, 15, 0, 0, 0, 0);
                applyStimulus(0, 15, 0, 0, 0, 0);
            end
            for (int w = 0; w < 2; w++) begin
                waitVld(2100, cyc, seen);
                checks++;
                if (!seen) begin errors++; $display("[TB] FAIL single_vld_timeout win%0d: no strobe in %0d clks", w, cyc); end
                else begin
                    checks++;
                    if (cyc !== ((w == 0) ? WIN + 1 : WIN))
                        begin errors++; $display("[TB] FAIL single_period win%0d: got %0d clks, expected %0d", w, cyc, (w == 0) ? WIN + 1 : WIN); end
                    checks++;
                    if (sbQ.size() == 0) begin errors++; $display("[TB] FAIL single_sb win%0d: strobe with empty scoreboard", w); end
                    else begin
                        exp = sbQ.pop_front();
                        if (observed() !== exp)
                            begin errors++; $display("[TB] FAIL single_value win%0d: got %s, expected %s", w, fmt(observed()), fmt(exp)); end
                    end
                end
            end
        join
        stopMeas();
    endtask

    // Left reverse against right forward on one strobe, then net-duty windows.
    task automatic test_net_duty();
        int cyc; bit seen; res_t exp;
        startMeas();
        fork
            begin
                applyStimulus(0, 0, 255, 0, 255, 0);
                applyStimulus(0, 1000, 300, 0, 300, 1000);
                applyStimulus(0, 300, 1000, 0, 1000, 300);
                applyStimulus(0, 500, 500, 0, 7, 7);
            end
            for (int w = 0; w < 4; w++) begin
                waitVld(2100, cyc, seen);
                checks++;
                if (!seen) begin errors++; $display("[TB] FAIL net_vld_timeout win%0d: no strobe in %0d clks", w, cyc); end
                else begin
                    checks++;
                    if (sbQ.size() == 0) begin errors++; $display("[TB] FAIL net_sb win%0d: strobe with empty scoreboard", w); end
                    else begin
                        exp = sbQ.pop_front();
                        if (observed() !== exp)
                            begin errors++; $display("[TB] FAIL net_value win%0d: got %s, expected %s", w, fmt(observed()), fmt(exp)); end
                    end
                end
            end
        join
        stopMeas();
    endtask

    // Constant-high forward saturates, constant-high reverse saturates with
    // direction, then an idle window reads zero.
    task automatic test_saturation();
        int cyc; bit seen; res_t exp;
        startMeas();
        fork
            begin
                applyStimulus(0, WIN, 0, 0, 0, WIN);
                applyStimulus(0, 0, 0, 0, 0, 0);
            end
            for (int w = 0; w < 2; w++) begin
                waitVld(2100, cyc, seen);
                checks++;
                if (!seen) begin errors++; $display("[TB] FAIL sat_vld_timeout win%0d: no strobe in %0d clks", w, cyc); end
                else begin
                    checks++;
                    if (sbQ.size() == 0) begin errors++; $display("[TB] FAIL sat_sb win%0d: strobe with empty scoreboard", w); end
                    else begin
                        exp = sbQ.pop_front();
                        if (observed() !== exp)
                            begin errors++; $display("[TB] FAIL sat_value win%0d: got %s, expected %s", w, fmt(observed()), fmt(exp)); end
                    end
                end
            end
        join
        stopMeas();
    endtask

    // Shoot-through cycles count in neither direction and set the flag for
    // that window only; the right side uses a different pattern.
    task automatic test_shoot();
        int cyc; bit seen; res_t exp;
        startMeas();
        fork
            begin
                applyStimulus(10, 100, 0, 3, 0, 40);
                applyStimulus(0, 100, 0, 0, 0, 40);
            end
            for (int w = 0; w < 2; w++) begin
                waitVld(2100, cyc, seen);
                checks++;
                if (!seen) begin errors++; $display("[TB] FAIL shoot_vld_timeout win%0d: no strobe in %0d clks", w, cyc); end
                else begin
                    checks++;
                    if (sbQ.size() == 0) begin errors++; $display("[TB] FAIL shoot_sb win%0d: strobe with empty scoreboard", w); end
                    else begin
                        exp = sbQ.pop_front();
                        if (observed() !== exp)
                            begin errors++; $display("[TB] FAIL shoot_value win%0d: got %s, expected %s", w, fmt(observed()), fmt(exp)); end
                    end
                end
            end
        join
        stopMeas();
    endtask

    // Enable drops part-way into a window: no strobe, outputs hold; a fresh
    // enable gives a full window and the first-strobe latency again.
    task automatic test_en_drop();
        int cyc; bit seen; res_t exp; res_t held;
        held = '0;
        startMeas();
        fork
            begin
                applyStimulus(0, 200, 0, 0, 0, 120);
                for (int i = 0; i < 1000; i++) @(negedge clk);
                @(negedge clk);
                bus.en = 1'b0;
            end
            begin
                waitVld(2100, cyc, seen);
                checks++;
                if (!seen) begin errors++; $display("[TB] FAIL drop_vld_timeout: no strobe in %0d clks", cyc); end
                else begin
                    checks++;
                    if (sbQ.size() == 0) begin errors++; $display("[TB] FAIL drop_sb: strobe with empty scoreboard"); end
                    else begin
                        exp  = sbQ.pop_front();
                        held = exp;
                        if (observed() !== exp)
                            begin errors++; $display("[TB] FAIL drop_value: got %s, expected %s", fmt(observed()), fmt(exp)); end
                    end
                end
            end
        join
        waitVld(3000, cyc, seen);
        checks++;
        if (seen) begin errors++; $display("[TB] FAIL drop_no_vld: got strobe after %0d clks, expected none", cyc); end
        checks++;
        if (observed() !== held)
            begin errors++; $display("[TB] FAIL drop_hold: got %s, expected %s", fmt(observed()), fmt(held)); end
        stopMeas();
        startMeas();
        fork
            applyStimulus(0, 50, 0, 0, 0, 0);
            begin
                waitVld(2100, cyc, seen);
                checks++;
                if (!seen) begin errors++; $display("[TB] FAIL reen_vld_timeout: no strobe in %0d clks", cyc); end
                else begin
                    checks++;
                    if (cyc !== WIN + 1)
                        begin errors++; $display("[TB] FAIL reen_latency: got %0d clks, expected %0d", cyc, WIN + 1); end
                    checks++;
                    if (sbQ.size() == 0) begin errors++; $display("[TB] FAIL reen_sb: strobe with empty scoreboard"); end
                    else begin
                        exp = sbQ.pop_front();
                        if (observed() !== exp)
                            begin errors++; $display("[TB] FAIL reen_value: got %s, expected %s", fmt(observed()), fmt(exp)); end
                    end
                end
            end
        join
        stopMeas();
    endtask

    // Asynchronous reset while the strobe is high and outputs are non-zero.
    task automatic test_reset_mid();
        int cyc; bit seen; res_t exp;
        startMeas();
        fork
            applyStimulus(0, 77, 0, 2, 0, 33);
            begin
                waitVld(2100, cyc, seen);
                checks++;
                if (!seen) begin errors++; $display("[TB] FAIL rstmid_vld_timeout: no strobe in %0d clks", cyc); end
                else begin
                    checks++;
                    if (sbQ.size() == 0) begin errors++; $display("[TB] FAIL rstmid_sb: strobe with empty scoreboard"); end
                    else begin
                        exp = sbQ.pop_front();
                        if (observed() !== exp)
                            begin errors++; $display("[TB] FAIL rstmid_value: got %s, expected %s", fmt(observed()), fmt(exp)); end
                    end
                end
            end
        join
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (observed() !== '0)
            begin errors++; $display("[TB] FAIL rstmid_outputs: got %s, expected all 0", fmt(observed())); end
        checks++;
        if (bus.meas_vld !== 1'b0)
            begin errors++; $display("[TB] FAIL rstmid_vld: got %b, expected 0", bus.meas_vld); end
        @(negedge clk);
        rst_n = 1'b1;
        stopMeas();
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_single_frwrd();
        test_net_duty();
        test_saturation();
        test_shoot();
        test_en_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
